// File: rtl/demux_eight_reg.sv
// Registered 1-to-8 demultiplexer: steers one input word into one of eight
// single-entry channel holding registers, each with its own valid/ready handshake.
module demux_eight_reg #(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [WIDTH-1:0]   bus_i,
  input  logic [2:0]         select_i,
  input  logic               valid_i,
  output logic               ready_o,
  output logic [WIDTH-1:0]   bus_a_o,
  output logic [WIDTH-1:0]   bus_b_o,
  output logic [WIDTH-1:0]   bus_c_o,
  output logic [WIDTH-1:0]   bus_d_o,
  output logic [WIDTH-1:0]   bus_e_o,
  output logic [WIDTH-1:0]   bus_f_o,
  output logic [WIDTH-1:0]   bus_g_o,
  output logic [WIDTH-1:0]   bus_h_o,
  output logic [7:0]         valid_o,
  input  logic [7:0]         ready_i,
  output logic [COUNT_W-1:0] count_o
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } ch_state_t;

  logic [WIDTH-1:0]   w_bus [8];
  logic [7:0]         w_valid;
  logic [7:0]         w_load;
  logic               w_accept;
  logic [COUNT_W-1:0] r_count;

  // A full channel still accepts when its consumer drains it on the same edge.
  assign ready_o  = ~w_valid[select_i] | ready_i[select_i];
  assign w_accept = valid_i & ready_o;
  assign w_load   = {8{w_accept}} & (8'b1 << select_i);

  for (genvar gi = 0; gi < 8; gi++) begin : g_ch
    ch_state_t        r_state;
    ch_state_t        w_state_next;
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        r_state <= S_EMPTY;
        r_data  <= '0;
      end else begin
        r_state <= w_state_next;
        if (w_load[gi]) begin
          r_data <= bus_i;
        end
      end
    end

    always_comb begin
      w_state_next = r_state;
      if (r_state == S_EMPTY) begin
        if (w_load[gi]) begin
          w_state_next = S_FULL;
        end
      end else if (!w_load[gi] && ready_i[gi]) begin
        w_state_next = S_EMPTY;
      end
    end

    assign w_valid[gi] = (r_state == S_FULL);
    assign w_bus[gi]   = r_data;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_count <= '0;
    end else if (w_accept) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign bus_a_o = w_bus[0];
  assign bus_b_o = w_bus[1];
  assign bus_c_o = w_bus[2];
  assign bus_d_o = w_bus[3];
  assign bus_e_o = w_bus[4];
  assign bus_f_o = w_bus[5];
  assign bus_g_o = w_bus[6];
  assign bus_h_o = w_bus[7];
  assign valid_o = w_valid;
  assign count_o = r_count;

endmodule

// File: tb/tb_demux_eight_reg.sv
// Scoreboard bench for demux_eight_reg: stimulus pushes expected words per channel,
// a negedge monitor pops and compares whenever a consumer takes a word.
module tb_demux_eight_reg;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [7:0]  bus_i;
  logic [2:0]  select_i;
  logic        valid_i;
  logic [7:0]  ready_i;
  logic        ready_o, ready4;
  logic [7:0]  bus_a_o, bus_b_o, bus_c_o, bus_d_o, bus_e_o, bus_f_o, bus_g_o, bus_h_o;
  logic [7:0]  b4_a, b4_b, b4_c, b4_d, b4_e, b4_f, b4_g, b4_h;
  logic [7:0]  valid_o, valid4;
  logic [15:0] count_o;
  logic [3:0]  count4;
  logic [7:0]  w_bus [8];

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q [8][$];

  always #5 clk_i = ~clk_i;

  demux_eight_reg #(.WIDTH(8), .COUNT_W(16)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .bus_i(bus_i), .select_i(select_i), .valid_i(valid_i),
    .ready_o(ready_o), .bus_a_o(bus_a_o), .bus_b_o(bus_b_o), .bus_c_o(bus_c_o),
    .bus_d_o(bus_d_o), .bus_e_o(bus_e_o), .bus_f_o(bus_f_o), .bus_g_o(bus_g_o),
    .bus_h_o(bus_h_o), .valid_o(valid_o), .ready_i(ready_i), .count_o(count_o)
  );

  // Narrow-counter instance sees identical traffic; used for the wrap check.
  demux_eight_reg #(.WIDTH(8), .COUNT_W(4)) u_dut4 (
    .clk_i(clk_i), .rst_i(rst_i), .bus_i(bus_i), .select_i(select_i), .valid_i(valid_i),
    .ready_o(ready4), .bus_a_o(b4_a), .bus_b_o(b4_b), .bus_c_o(b4_c),
    .bus_d_o(b4_d), .bus_e_o(b4_e), .bus_f_o(b4_f), .bus_g_o(b4_g),
    .bus_h_o(b4_h), .valid_o(valid4), .ready_i(ready_i), .count_o(count4)
  );

  assign w_bus[0] = bus_a_o;
  assign w_bus[1] = bus_b_o;
  assign w_bus[2] = bus_c_o;
  assign w_bus[3] = bus_d_o;
  assign w_bus[4] = bus_e_o;
  assign w_bus[5] = bus_f_o;
  assign w_bus[6] = bus_g_o;
  assign w_bus[7] = bus_h_o;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic [2:0] sel, input logic [7:0] data);
    select_i = sel;
    bus_i    = data;
    valid_i  = 1'b1;
    exp_q[sel].push_back(data);
    tick();
    valid_i  = 1'b0;
  endtask

  always @(negedge clk_i) begin
    if (!rst_i) begin
      for (int k = 0; k < 8; k++) begin
        if (valid_o[k] && ready_i[k]) begin
          if (exp_q[k].size() == 0) begin
            total++;
            bad++;
            $display("FAIL ch%0d_pop: got %0h expected no word at %0t", k, w_bus[k], $time);
          end else begin
            chk($sformatf("ch%0d_pop", k), {24'd0, w_bus[k]}, {24'd0, exp_q[k].pop_front()});
          end
        end
      end
    end
  end

  initial begin
    rst_i = 1'b1; bus_i = '0; select_i = '0; valid_i = 1'b0; ready_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("reset_valid", valid_o, 8'h00);
    chk("reset_count", count_o, 0);
    rst_i = 1'b0;
    tick();
    chk("idle_count", count_o, 0);
    chk("idle_ready", ready_o, 1);

    // Steer one word into each channel with no consumers.
    for (int k = 0; k < 8; k++) send(3'(k), 8'hA0 + 8'(k));
    chk("steer_valid", valid_o, 8'hFF);
    chk("steer_count", count_o, 8);
    for (int k = 0; k < 8; k++) chk($sformatf("steer_bus%0d", k), w_bus[k], 8'hA0 + 8'(k));

    // Empty channel 5, then backpressure on full channel 3 while 5 accepts.
    ready_i = 8'h20;
    tick();
    ready_i = 8'h00;
    chk("rel5_valid", valid_o, 8'hDF);
    select_i = 3'd3; bus_i = 8'h55; valid_i = 1'b1;
    #1;
    chk("bp_ready3", ready_o, 0);
    tick();
    valid_i = 1'b0;
    chk("bp_bus_d", bus_d_o, 8'hA3);
    chk("bp_count", count_o, 8);
    select_i = 3'd5;
    #1;
    chk("bp_ready5", ready_o, 1);
    send(3'd5, 8'h55);
    chk("acc5_bus_f", bus_f_o, 8'h55);
    chk("acc5_count", count_o, 9);
    chk("acc5_valid", valid_o, 8'hFF);

    // Release-only on channel 7.
    ready_i = 8'h80;
    tick();
    ready_i = 8'h00;
    chk("rel7_valid", valid_o, 8'h7F);
    chk("rel7_bus_h", bus_h_o, 8'hA7);

    // Streaming through channel 2 with its consumer always ready.
    ready_i = 8'h04;
    for (int i = 1; i <= 10; i++) begin
      select_i = 3'd2;
      bus_i    = 8'(i);
      #1;
      chk("stream_ready", ready_o, 1);
      send(3'd2, 8'(i));
      chk("stream_valid2", valid_o[2], 1);
      chk("stream_bus_c", bus_c_o, 8'(i));
    end
    tick();
    chk("stream_drained", valid_o[2], 0);
    chk("stream_count", count_o, 19);
    chk("stream_count4", count4, 3);
    ready_i = 8'h00;

    // Refill to all-full, then async reset mid-cycle.
    send(3'd2, 8'hC2);
    send(3'd7, 8'hC7);
    chk("prerst_valid", valid_o, 8'hFF);
    chk("prerst_count", count_o, 21);
    #2;
    rst_i = 1'b1;
    for (int k = 0; k < 8; k++) exp_q[k].delete();
    #1;
    chk("async_valid", valid_o, 8'h00);
    chk("async_count", count_o, 0);
    chk("async_count4", count4, 0);
    for (int k = 0; k < 8; k++) chk($sformatf("async_bus%0d", k), w_bus[k], 8'h00);
    tick();
    rst_i = 1'b0;
    tick();
    chk("postrst_valid", valid_o, 8'h00);

    // 17 accepts: the 4-bit counter wraps to 1.
    ready_i = 8'hFF;
    for (int i = 0; i < 17; i++) send(3'(i % 8), 8'h30 + 8'(i));
    tick();
    chk("wrap_count4", count4, 1);
    chk("wrap_count", count_o, 17);
    chk("wrap_valid", valid_o, 8'h00);

    tick();
    begin
      int left;
      left = 0;
      for (int k = 0; k < 8; k++) left += exp_q[k].size();
      chk("queues_empty", left, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
